// File: rtl/clock_pkg.sv
// Shared types and helpers for the time display path: converter state
// encoding and the active-low 7-segment decoder.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes go dark.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble: 24-bit binary to 8 BCD digits,
// one conversion every 26 cycles (IDLE, 24 x SHIFT, DONE).
module bin2bcd_seq
    import clock_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bin,
    output logic [31:0] bcd,
    output logic        bcd_valid
);

    b2b_state_t  state_q, state_d;
    logic [55:0] sh_q, sh_d;
    logic [55:0] adj;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;

    // bcd/valid are loaded on the final shift edge so both appear together
    // during the DONE cycle.
    always_comb begin
        adj = sh_q;
        for (int k = 0; k < 8; k++) begin
            if (sh_q[24 + 4*k +: 4] >= 4'd5)
                adj[24 + 4*k +: 4] = sh_q[24 + 4*k +: 4] + 4'd3;
        end

        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                sh_d    = {32'b0, bin};
                cnt_d   = 5'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sh_d  = {adj[54:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = DONE;
                    bcd_d   = sh_d[55:24];
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= 56'd0;
            cnt_q   <= 5'd0;
            bcd_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: rtl/time_display_driver.sv
// Converts the clock's binary time value to BCD and scans it onto the
// 8-digit multiplexed 7-segment display with HH.MM.SS dots.
module time_display_driver
    import clock_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int DIGIT_RATE_HZ = 1_000,
    parameter int NUM_DIGITS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] number,
    input  logic        blank_en,
    output logic [31:0] bcd,
    output logic        bcd_valid,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV   = CLK_FREQ_HZ / DIGIT_RATE_HZ;
    localparam int DW    = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [31:0]      bcd_w;
    logic [DW-1:0]    div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick;
    logic [3:0]       digit;
    logic             blank;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    bin2bcd_seq u_conv (
        .clk       (clk),
        .rst       (rst),
        .bin       (number),
        .bcd       (bcd_w),
        .bcd_valid (bcd_valid)
    );

    always_comb begin
        tick  = (div_q == DW'(DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
        idx_d = tick ? idx_q + 1'b1 : idx_q;

        // Display reads only the completed bcd, never the shift register.
        digit = bcd_w[{idx_q, 2'b00} +: 4];
        blank = blank_en && (bcd_w[31:24] == 8'h00) && (idx_q >= IDX_W'(6));
        an_d  = ~(8'b1 << idx_q);
        seg_d = blank ? SEG_BLANK : seg7_decode(digit);
        dp_d  = blank ? 1'b1 : !((idx_q == IDX_W'(2)) || (idx_q == IDX_W'(4)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bcd = bcd_w;
    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Directed plus randomized checks of time_display_driver against a decimal
// arithmetic reference model of conversion and scan timing.
module tb_time_display_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] number = 24'd0;
    logic        blank_en = 1'b0;
    logic [31:0] bcd;
    logic        bcd_valid;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;
    int n_edges = 0;

    time_display_driver #(
        .CLK_FREQ_HZ   (1000),
        .DIGIT_RATE_HZ (250),
        .NUM_DIGITS    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .number    (number),
        .blank_en  (blank_en),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was released.
    always @(posedge clk) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    function automatic logic [31:0] model_bcd(input int unsigned n);
        logic [31:0] r;
        int unsigned v;
        r = 32'd0;
        v = n;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input logic [3:0] d);
        logic [6:0] pat [10];
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
        return (d < 4'd10) ? pat[d] : 7'h7F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_bcd", bcd, 32'd0);
        check("rst_valid", {31'd0, bcd_valid}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_pulse(output int at_edge);
        at_edge = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bcd_valid === 1'b1) begin
                at_edge = n_edges;
                return;
            end
        end
        checks++;
        errors++;
        $error("FAIL pulse_timeout: observed none expected bcd_valid within 60 cycles");
    endtask

    task automatic convert_and_check(input string tag, input logic [23:0] val);
        int e;
        number = val;
        wait_pulse(e);
        wait_pulse(e);
        check(tag, bcd, model_bcd(val));
    endtask

    // Output registers at edge N reflect the digit index reached after N-1 edges.
    task automatic check_scan(input string tag, input int cycles, input logic [31:0] exp_bcd);
        int n, idx;
        logic [3:0] d;
        logic bl;
        logic [7:0] exp_an;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n      = n_edges;
            idx    = ((n - 1) / 4) % 8;
            exp_an = ~(8'b1 << idx);
            d      = exp_bcd[4*idx +: 4];
            bl     = blank_en && (exp_bcd[31:24] == 8'h00) && (idx >= 6);
            check({tag, "_an"}, {24'd0, an}, {24'd0, exp_an});
            check({tag, "_seg"}, {25'd0, seg}, {25'd0, bl ? 7'h7F : model_seg(d)});
            check({tag, "_dp"}, {31'd0, dp}, {31'd0, (bl || !(idx == 2 || idx == 4))});
        end
    endtask

    initial begin
        int e;
        int unsigned r;

        // Reset and first conversion timing
        number = 24'd235959;
        do_reset(3);
        wait_pulse(e);
        check("first_pulse_edge", e, 25);
        check("bcd_235959", bcd, 32'h00235959);
        wait_pulse(e);
        check("second_pulse_edge", e, 51);
        check("bcd_235959_again", bcd, model_bcd(235959));
        check_scan("scan_235959", 40, 32'h00235959);

        // Extremes
        convert_and_check("bcd_max", 24'hFFFFFF);
        check("bcd_max_const", bcd, 32'h16777215);
        convert_and_check("bcd_zero", 24'd0);

        // Leading-digit blanking
        blank_en = 1'b1;
        convert_and_check("bcd_5", 24'd5);
        check_scan("scan_blank", 36, 32'h00000005);
        blank_en = 1'b0;
        check_scan("scan_noblank", 36, 32'h00000005);

        // Input change mid-SHIFT is deferred to the next capture
        number = 24'd100;
        do_reset(2);
        repeat (10) @(negedge clk);
        number = 24'd200;
        wait_pulse(e);
        check("midshift_pulse_edge", e, 25);
        check("midshift_old", bcd, 32'h00000100);
        wait_pulse(e);
        check("midshift_new", bcd, 32'h00000200);

        // Reset mid-SHIFT aborts without a pulse
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_bcd", bcd, 32'd0);
        check("abort_valid", {31'd0, bcd_valid}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_bcd_hold", bcd, 32'd0);
        wait_pulse(e);
        check("abort_pulse_edge", e, 25);
        check("abort_bcd_after", bcd, 32'h00000200);

        // Randomized values and blanking
        for (int t = 0; t < 8; t++) begin
            r = $urandom_range(0, 24'hFFFFFF);
            if (t % 3 == 0) r = r % 100;
            blank_en = 1'($urandom_range(0, 1));
            convert_and_check("rand_bcd", 24'(r));
            check_scan("rand_scan", 12, model_bcd(r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
